gpr_regfile: RTL and testbench
==============================

// Module: gpr_regfile
// PURPOSE
//   Architectural integer register file for the RV64 core: 2 async read ports, 1 sync write port, x0 hardwired to 0.
//   Keeps a commit-aligned snapshot bank of all GPRs and drives it on gpr_0..gpr_31 to the DPI-C regfile shim
//   directly downstream, so the simulator/difftest sees state that matches retired instructions only.
//   Also maintains a retired-instruction counter and a one-cycle snapshot-ready strobe for difftest stepping.
// PARAMETERS
//   XLEN    64  register width; must stay 64 to match the downstream DPI-C shim ports
//   NR_GPR  32  number of GPRs; fixed at 32, with addresses of AW=5 bits
// PORTS
//   clk           input   1     core clock; all state updates on posedge
//   rst           input   1     synchronous reset, active-low (0 = reset)
//   rs1_addr      input   5     read port 1 address
//   rs1_data      output  XLEN  read port 1 data (combinational)
//   rs2_addr      input   5     read port 2 address
//   rs2_data      output  XLEN  read port 2 data (combinational)
//   wen           input   1     write enable from write-back stage
//   waddr         input   5     write address
//   wdata         input   XLEN  write data
//   commit_valid  input   1     the WB instruction retires this cycle; its write, if any, is on wen/waddr/wdata
//   snap_valid    output  1     1-cycle strobe: snapshot bank updated on previous edge
//   commit_cnt    output  64    retired-instruction count
//   gpr_0..gpr_31 output  XLEN  snapshot bank, one port per GPR, feeds the DPI-C shim; gpr_0 is constant 0
// BEHAVIOUR
//   Reset: at a posedge with rst==0, rf[1..31], snap[1..31], commit_cnt and snap_valid are set to 0.
//     All inputs are ignored in that cycle, including wen and commit_valid. rf[0]/snap[0] are not storage; they read 0.
//   Write: at a posedge with rst==1, wen==1 and waddr!=0, rf[waddr] <= wdata. A write to waddr==0 is discarded.
//   Read: rsN_data = (rsN_addr==0) ? 0 : rf[rsN_addr]. Zero latency, combinational from address.
//   Snapshot: at a posedge with rst==1 and commit_valid==1, snap[i] <= next-state of rf[i] for all i.
//     The next state includes the same-cycle write, so snap[waddr] gets wdata when wen==1 and waddr!=0.
//     With commit_valid==0, snap holds even if rf is written. This covers speculative/non-retiring writes and multi-cycle ops.
//   gpr_i = snap[i] (registered outputs, no combinational path from inputs).
//   commit_cnt: +1 on each posedge with rst==1 and commit_valid==1; wraps 2^64-1 -> 0.
//   snap_valid: registered copy of commit_valid, so it is high exactly in the cycle after a commit edge.
//     Back-to-back commits keep it high continuously.
//   No stall/handshake: the block accepts wen/commit_valid every cycle; upstream guarantees one write max per cycle.
//   Reset mid-operation: a commit coinciding with rst==0 is lost. The next cycle shows snap_valid=0 and commit_cnt=0.
// CONFIGURATION
//   RF_BYPASS_EN defined:
//     If wen==1, waddr!=0 and rsN_addr==waddr, rsN_data = wdata in the same cycle (write-to-read forwarding).
//     Reads of x0 still return 0.
//   RF_BYPASS_EN undefined:
//     Reads return the stored rf value; the new value becomes visible the cycle after the write edge.
//     The pipeline must handle this hazard.
//   Snapshot, counter and reset behaviour are identical in both builds.
// TESTING
//   1. Reset: hold rst=0 for 2 cycles with wen=1, waddr=5, wdata=0xDEAD -> rf/gpr_* all 0, commit_cnt=0, snap_valid=0.
//   2. x0: wen=1, waddr=0, wdata=0xFFFF_FFFF_FFFF_FFFF, commit_valid=1 -> rs1_data(addr 0)=0, gpr_0=0;
//      next cycle snap_valid=1, commit_cnt=1.
//   3. Commit alignment: write x3=0x1234 with commit_valid=0 -> rs1_data(3)=0x1234 next cycle, gpr_3 stays 0;
//      then commit_valid=1 with wen=0 -> gpr_3=0x1234 after that edge.
//   4. Same-cycle write+commit: wen=1, waddr=31, wdata=0xA5A5..A5, commit_valid=1 ->
//      after one edge gpr_31=0xA5A5..A5 and snap_valid=1.
//   5. Bypass: rs1_addr=rs2_addr=7, wen=1, waddr=7, wdata=0x55 in one cycle ->
//      with RF_BYPASS_EN both read 0x55 in that cycle; without it both read the old x7 until the next cycle.
//   6. Counter wrap and reset mid-run: force commit_cnt=2^64-1, commit once -> commit_cnt=0.
//      Assert rst=0 on a commit cycle -> commit_cnt=0, snap_valid=0, and gpr_* are cleared.

Source files
------------

// File: rtl/gpr_regfile.sv
// gpr_regfile: RV64 architectural register file with a commit-aligned snapshot bank for difftest.
// Define RF_BYPASS_EN to forward a same-cycle write to both read ports.
module gpr_regfile #(
  parameter  int XLEN   = 64,
  parameter  int NR_GPR = 32,
  localparam int AW     = $clog2(NR_GPR)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  output logic [XLEN-1:0] rs1_data,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wen,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic            commit_valid,
  output logic            snap_valid,
  output logic [63:0]     commit_cnt,
  output logic [XLEN-1:0] gpr_0,  gpr_1,  gpr_2,  gpr_3,  gpr_4,  gpr_5,  gpr_6,  gpr_7,
  output logic [XLEN-1:0] gpr_8,  gpr_9,  gpr_10, gpr_11, gpr_12, gpr_13, gpr_14, gpr_15,
  output logic [XLEN-1:0] gpr_16, gpr_17, gpr_18, gpr_19, gpr_20, gpr_21, gpr_22, gpr_23,
  output logic [XLEN-1:0] gpr_24, gpr_25, gpr_26, gpr_27, gpr_28, gpr_29, gpr_30, gpr_31
);

  // x0 has no storage in either bank; index 0 is always decoded to a constant zero.
  logic [XLEN-1:0] rf_q   [1:NR_GPR-1];
  logic [XLEN-1:0] rf_d   [1:NR_GPR-1];
  logic [XLEN-1:0] snap_q [1:NR_GPR-1];
  logic [XLEN-1:0] snap_d [1:NR_GPR-1];
  logic [63:0]     cnt_q;
  logic            snap_valid_q;

  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
    logic [XLEN-1:0] val;
    val = '0;
    if (addr != '0) begin
`ifdef RF_BYPASS_EN
      if (wen && (waddr == addr)) val = wdata;
      else                        val = rf_q[addr];
`else
      val = rf_q[addr];
`endif
    end
    return val;
  endfunction

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    rf_d = rf_q;
    if (wen && (waddr != '0)) rf_d[waddr] = wdata;
    // The snapshot takes the post-write register state so a retiring write is visible immediately.
    snap_d = commit_valid ? rf_d : snap_q;
    rs1_data = read_port(rs1_addr);
    rs2_data = read_port(rs2_addr);
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values, independent of order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the register arrays are reset explicitly because difftest compares them from the first commit.
      rf_q         <= '{default: '0};
      snap_q       <= '{default: '0};
      cnt_q        <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      rf_q         <= rf_d;
      snap_q       <= snap_d;
      snap_valid_q <= commit_valid;
      if (commit_valid) cnt_q <= cnt_q + 64'd1;
    end
  end

  assign snap_valid = snap_valid_q;
  assign commit_cnt = cnt_q;

  assign gpr_0  = '0;
  assign gpr_1  = snap_q[1];
  assign gpr_2  = snap_q[2];
  assign gpr_3  = snap_q[3];
  assign gpr_4  = snap_q[4];
  assign gpr_5  = snap_q[5];
  assign gpr_6  = snap_q[6];
  assign gpr_7  = snap_q[7];
  assign gpr_8  = snap_q[8];
  assign gpr_9  = snap_q[9];
  assign gpr_10 = snap_q[10];
  assign gpr_11 = snap_q[11];
  assign gpr_12 = snap_q[12];
  assign gpr_13 = snap_q[13];
  assign gpr_14 = snap_q[14];
  assign gpr_15 = snap_q[15];
  assign gpr_16 = snap_q[16];
  assign gpr_17 = snap_q[17];
  assign gpr_18 = snap_q[18];
  assign gpr_19 = snap_q[19];
  assign gpr_20 = snap_q[20];
  assign gpr_21 = snap_q[21];
  assign gpr_22 = snap_q[22];
  assign gpr_23 = snap_q[23];
  assign gpr_24 = snap_q[24];
  assign gpr_25 = snap_q[25];
  assign gpr_26 = snap_q[26];
  assign gpr_27 = snap_q[27];
  assign gpr_28 = snap_q[28];
  assign gpr_29 = snap_q[29];
  assign gpr_30 = snap_q[30];
  assign gpr_31 = snap_q[31];

endmodule

// File: tb/tb_gpr_regfile.sv
// tb_gpr_regfile: directed and randomized checks of gpr_regfile against an array-level reference model.
// Expected read values follow RF_BYPASS_EN the same way the design does.
module tb_gpr_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_addr, rs2_addr, waddr;
  logic [63:0] rs1_data, rs2_data, wdata;
  logic        wen, commit_valid, snap_valid;
  logic [63:0] commit_cnt;
  logic [63:0] gpr [32];

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: architectural state as plain arrays, entry 0 always zero.
  logic [63:0] rf_m   [32];
  logic [63:0] snap_m [32];
  logic [63:0] cnt_m;
  logic        sv_m;

`ifdef RF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  always #5 clk = ~clk;

  gpr_regfile dut (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs1_data(rs1_data), .rs2_addr(rs2_addr), .rs2_data(rs2_data),
    .wen(wen), .waddr(waddr), .wdata(wdata), .commit_valid(commit_valid),
    .snap_valid(snap_valid), .commit_cnt(commit_cnt),
    .gpr_0(gpr[0]),   .gpr_1(gpr[1]),   .gpr_2(gpr[2]),   .gpr_3(gpr[3]),
    .gpr_4(gpr[4]),   .gpr_5(gpr[5]),   .gpr_6(gpr[6]),   .gpr_7(gpr[7]),
    .gpr_8(gpr[8]),   .gpr_9(gpr[9]),   .gpr_10(gpr[10]), .gpr_11(gpr[11]),
    .gpr_12(gpr[12]), .gpr_13(gpr[13]), .gpr_14(gpr[14]), .gpr_15(gpr[15]),
    .gpr_16(gpr[16]), .gpr_17(gpr[17]), .gpr_18(gpr[18]), .gpr_19(gpr[19]),
    .gpr_20(gpr[20]), .gpr_21(gpr[21]), .gpr_22(gpr[22]), .gpr_23(gpr[23]),
    .gpr_24(gpr[24]), .gpr_25(gpr[25]), .gpr_26(gpr[26]), .gpr_27(gpr[27]),
    .gpr_28(gpr[28]), .gpr_29(gpr[29]), .gpr_30(gpr[30]), .gpr_31(gpr[31])
  );

  task automatic drive(input logic r, input logic we, input logic [4:0] wa, input logic [63:0] wd,
                       input logic cv, input logic [4:0] a1, input logic [4:0] a2);
    rst = r; wen = we; waddr = wa; wdata = wd; commit_valid = cv; rs1_addr = a1; rs2_addr = a2;
  endtask

  // Advance one clock edge, applying the architectural rules to the model, and stop at the next negedge.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin rf_m[i] = '0; snap_m[i] = '0; end
      cnt_m = '0;
      sv_m  = 1'b0;
    end else begin
      if (wen && waddr != 0) rf_m[waddr] = wdata;
      if (commit_valid) begin
        snap_m = rf_m;
        cnt_m  = cnt_m + 64'd1;
      end
      sv_m = commit_valid;
    end
    @(negedge clk);
  endtask

  function automatic logic [63:0] exp_read(input logic [4:0] a);
    if (a == 0) return '0;
    if (BYPASS && wen && waddr == a) return wdata;
    return rf_m[a];
  endfunction

  task automatic test_reset();
    drive(1'b0, 1'b1, 5'd5, 64'hDEAD, 1'b1, 5'd5, 5'd0);
    tick();
    tick();
    n_total++; if (commit_cnt !== 64'd0) $display("FAIL reset_cnt: got %0d want 0", commit_cnt); else n_pass++;
    n_total++; if (snap_valid !== 1'b0) $display("FAIL reset_snap_valid: got %b want 0", snap_valid); else n_pass++;
    for (int i = 0; i < 32; i++) begin
      n_total++; if (gpr[i] !== 64'd0) $display("FAIL reset_gpr%0d: got %h want 0", i, gpr[i]); else n_pass++;
    end
    drive(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd5, 5'd5);
    #1;
    n_total++; if (rs1_data !== 64'd0) $display("FAIL reset_rf5: got %h want 0", rs1_data); else n_pass++;
  endtask

  task automatic test_x0();
    drive(1'b1, 1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd0, 5'd0);
    #1;
    n_total++; if (rs1_data !== 64'd0) $display("FAIL x0_read_same: got %h want 0", rs1_data); else n_pass++;
    tick();
    drive(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0);
    #1;
    n_total++; if (rs1_data !== 64'd0) $display("FAIL x0_read_after: got %h want 0", rs1_data); else n_pass++;
    n_total++; if (gpr[0] !== 64'd0) $display("FAIL x0_gpr0: got %h want 0", gpr[0]); else n_pass++;
    n_total++; if (snap_valid !== 1'b1) $display("FAIL x0_snap_valid: got %b want 1", snap_valid); else n_pass++;
    n_total++; if (commit_cnt !== 64'd1) $display("FAIL x0_cnt: got %0d want 1", commit_cnt); else n_pass++;
  endtask

  task automatic test_commit_align();
    drive(1'b1, 1'b1, 5'd3, 64'h1234, 1'b0, 5'd3, 5'd3);
    tick();
    drive(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd3, 5'd0);
    #1;
    n_total++; if (rs1_data !== 64'h1234) $display("FAIL align_read: got %h want 1234", rs1_data); else n_pass++;
    n_total++; if (gpr[3] !== 64'd0) $display("FAIL align_gpr3_hold: got %h want 0", gpr[3]); else n_pass++;
    n_total++; if (snap_valid !== 1'b0) $display("FAIL align_sv_low: got %b want 0", snap_valid); else n_pass++;
    drive(1'b1, 1'b0, 5'd0, 64'd0, 1'b1, 5'd3, 5'd0);
    tick();
    n_total++; if (gpr[3] !== 64'h1234) $display("FAIL align_gpr3_commit: got %h want 1234", gpr[3]); else n_pass++;
    n_total++; if (commit_cnt !== 64'd2) $display("FAIL align_cnt: got %0d want 2", commit_cnt); else n_pass++;
  endtask

  task automatic test_same_cycle();
    drive(1'b1, 1'b1, 5'd31, 64'hA5A5_A5A5_A5A5_A5A5, 1'b1, 5'd0, 5'd0);
    tick();
    drive(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd31, 5'd0);
    #1;
    n_total++; if (gpr[31] !== 64'hA5A5_A5A5_A5A5_A5A5) $display("FAIL same_gpr31: got %h want a5a5a5a5a5a5a5a5", gpr[31]); else n_pass++;
    n_total++; if (snap_valid !== 1'b1) $display("FAIL same_snap_valid: got %b want 1", snap_valid); else n_pass++;
    tick();
    n_total++; if (snap_valid !== 1'b0) $display("FAIL same_sv_drop: got %b want 0", snap_valid); else n_pass++;
  endtask

  task automatic test_bypass();
    logic [63:0] exp_same;
    drive(1'b1, 1'b1, 5'd7, 64'h11, 1'b1, 5'd0, 5'd0);
    tick();
    drive(1'b1, 1'b1, 5'd7, 64'h55, 1'b0, 5'd7, 5'd7);
    #1;
    exp_same = BYPASS ? 64'h55 : 64'h11;
    n_total++; if (rs1_data !== exp_same) $display("FAIL bypass_rs1_same: got %h want %h", rs1_data, exp_same); else n_pass++;
    n_total++; if (rs2_data !== exp_same) $display("FAIL bypass_rs2_same: got %h want %h", rs2_data, exp_same); else n_pass++;
    tick();
    drive(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd7, 5'd7);
    #1;
    n_total++; if (rs1_data !== 64'h55) $display("FAIL bypass_rs1_next: got %h want 55", rs1_data); else n_pass++;
    n_total++; if (rs2_data !== 64'h55) $display("FAIL bypass_rs2_next: got %h want 55", rs2_data); else n_pass++;
    n_total++; if (gpr[7] !== 64'h11) $display("FAIL bypass_gpr7_hold: got %h want 11", gpr[7]); else n_pass++;
  endtask

  task automatic test_wrap_and_reset();
    drive(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0);
    force dut.cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.cnt_q;
    cnt_m = 64'hFFFF_FFFF_FFFF_FFFF;
    drive(1'b1, 1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 5'd0);
    tick();
    n_total++; if (commit_cnt !== 64'd0) $display("FAIL wrap_cnt: got %h want 0", commit_cnt); else n_pass++;
    drive(1'b1, 1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 5'd0);
    tick();
    n_total++; if (commit_cnt !== 64'd1) $display("FAIL wrap_cnt_next: got %h want 1", commit_cnt); else n_pass++;
    drive(1'b0, 1'b1, 5'd9, 64'h99, 1'b1, 5'd0, 5'd0);
    tick();
    n_total++; if (commit_cnt !== 64'd0) $display("FAIL rst_mid_cnt: got %0d want 0", commit_cnt); else n_pass++;
    n_total++; if (snap_valid !== 1'b0) $display("FAIL rst_mid_sv: got %b want 0", snap_valid); else n_pass++;
    for (int i = 0; i < 32; i++) begin
      n_total++; if (gpr[i] !== 64'd0) $display("FAIL rst_mid_gpr%0d: got %h want 0", i, gpr[i]); else n_pass++;
    end
    drive(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd9, 5'd31);
    #1;
    n_total++; if (rs1_data !== 64'd0) $display("FAIL rst_mid_x9: got %h want 0", rs1_data); else n_pass++;
    n_total++; if (rs2_data !== 64'd0) $display("FAIL rst_mid_x31: got %h want 0", rs2_data); else n_pass++;
  endtask

  task automatic test_random();
    logic [63:0] e1, e2;
    for (int n = 0; n < 200; n++) begin
      drive(($urandom_range(0, 39) != 0), $urandom_range(0, 1), 5'($urandom_range(0, 31)),
            {$urandom, $urandom}, $urandom_range(0, 1),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) rs1_addr = waddr;
      #1;
      e1 = exp_read(rs1_addr);
      e2 = exp_read(rs2_addr);
      n_total++; if (rs1_data !== e1) $display("FAIL rnd_rs1 @%0d: got %h want %h", n, rs1_data, e1); else n_pass++;
      n_total++; if (rs2_data !== e2) $display("FAIL rnd_rs2 @%0d: got %h want %h", n, rs2_data, e2); else n_pass++;
      tick();
      n_total++; if (commit_cnt !== cnt_m) $display("FAIL rnd_cnt @%0d: got %0d want %0d", n, commit_cnt, cnt_m); else n_pass++;
      n_total++; if (snap_valid !== sv_m) $display("FAIL rnd_sv @%0d: got %b want %b", n, snap_valid, sv_m); else n_pass++;
      for (int i = 0; i < 32; i++) begin
        n_total++; if (gpr[i] !== snap_m[i]) $display("FAIL rnd_gpr%0d @%0d: got %h want %h", i, n, gpr[i], snap_m[i]); else n_pass++;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin rf_m[i] = '0; snap_m[i] = '0; end
    cnt_m = '0;
    sv_m  = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0);
    @(negedge clk);
    test_reset();
    test_x0();
    test_commit_align();
    test_same_cycle();
    test_bypass();
    test_wrap_and_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
